// File: rtl/jtag_unlock_ctrl.sv
// jtag_unlock_ctrl: serial-password gate driving the JTAG write-lock register,
// with a failure counter and a timed lockout. Rev 1.0
`default_nettype none

module jtag_unlock_ctrl #(
  parameter int                    PW_WIDTH       = 32,
  parameter logic [PW_WIDTH-1:0]   PASSWORD       = 32'hA5C3_0F1E,
  parameter int                    MAX_ATTEMPTS   = 3,
  parameter int                    LOCKOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  shift_en,
  input  logic                                  tdi,
  input  logic                                  check,
  input  logic                                  relock,
  output logic                                  unlock_en,
  output logic                                  unlock_val,
  output logic                                  unlocked,
  output logic                                  in_lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_cnt
);

  localparam int CW = $clog2(PW_WIDTH + 1);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);

  localparam logic [CW-1:0] PW_FULL    = CW'(PW_WIDTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [FW-1:0] FAIL_ONE   = FW'(1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PW_WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [FW-1:0]       fail_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic                en_nxt, val_nxt;
  logic                pw_match;

  assign pw_match = (bit_cnt == PW_FULL) && (sr == PASSWORD);

  // Reset leaves unlock_en high so the downstream register is forced locked
  // on every edge reset is held, and for the scrub edge right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOCKED;
      sr         <= '0;
      bit_cnt    <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      unlock_en  <= 1'b1;
      unlock_val <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      fail_cnt   <= fail_nxt;
      timer      <= timer_nxt;
      unlock_en  <= en_nxt;
      unlock_val <= val_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    fail_nxt    = fail_cnt;
    timer_nxt   = timer;
    en_nxt      = 1'b0;
    val_nxt     = unlock_val;

    case (state)
      S_LOCKED: begin
        if (check) begin
          // check wins over a simultaneous shift: the pre-shift sr is judged
          sr_nxt      = '0;
          bit_cnt_nxt = '0;
          if (pw_match) begin
            state_nxt = S_UNLOCKED;
            fail_nxt  = '0;
            en_nxt    = 1'b1;
            val_nxt   = 1'b1;
          end else begin
            fail_nxt = fail_cnt + FAIL_ONE;
            if (fail_nxt == FAIL_MAX) begin
              state_nxt = S_LOCKOUT;
              timer_nxt = TIMER_LOAD;
            end
          end
        end else if (shift_en) begin
          sr_nxt = {sr[PW_WIDTH-2:0], tdi};
          if (bit_cnt != PW_FULL) begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end

      S_UNLOCKED: begin
        if (relock) begin
          state_nxt = S_LOCKED;
          en_nxt    = 1'b1;
          val_nxt   = 1'b0;
        end
      end

      S_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = S_LOCKED;
          fail_nxt  = '0;
          // The expiry edge already accepts a check; sr is empty, so it fails
          if (check) begin
            sr_nxt      = '0;
            bit_cnt_nxt = '0;
            fail_nxt    = FAIL_ONE;
            if (FAIL_ONE == FAIL_MAX) begin
              state_nxt = S_LOCKOUT;
              timer_nxt = TIMER_LOAD;
            end
          end
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end

      default: begin
        state_nxt   = S_LOCKED;
        sr_nxt      = '0;
        bit_cnt_nxt = '0;
        en_nxt      = 1'b1;
        val_nxt     = 1'b0;
      end
    endcase
  end

  assign unlocked   = (state == S_UNLOCKED);
  assign in_lockout = (state == S_LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_jtag_unlock_ctrl.sv
// Directed bench for jtag_unlock_ctrl: vector table plus multi-cycle sequences.
`default_nettype none

module tb_jtag_unlock_ctrl;

  localparam logic [31:0] PW = 32'hA5C3_0F1E;
  localparam int          LOCK_CYC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shift_en = 1'b0;
  logic       tdi = 1'b0;
  logic       check = 1'b0;
  logic       relock = 1'b0;
  logic       unlock_en, unlock_val, unlocked, in_lockout;
  logic [1:0] fail_cnt;

  int n_chk = 0;
  int n_fail = 0;

  jtag_unlock_ctrl #(
    .PW_WIDTH      (32),
    .PASSWORD      (PW),
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .tdi       (tdi),
    .check     (check),
    .relock    (relock),
    .unlock_en (unlock_en),
    .unlock_val(unlock_val),
    .unlocked  (unlocked),
    .in_lockout(in_lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sh, bit_in, chk_in, rel;
    logic       en, val, unl, lo;
    logic [1:0] fc;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic en, input logic val,
                         input logic unl, input logic lo, input logic [1:0] fc);
    chk({nm, ".en"},  32'(unlock_en),  32'(en));
    chk({nm, ".val"}, 32'(unlock_val), 32'(val));
    chk({nm, ".unl"}, 32'(unlocked),   32'(unl));
    chk({nm, ".lo"},  32'(in_lockout), 32'(lo));
    chk({nm, ".fc"},  32'(fail_cnt),   32'(fc));
  endtask

  // Shift the low n bits of w, MSB first
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shift_en = 1'b1;
      tdi      = w[i];
      tick();
    end
    shift_en = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic do_check();
    check = 1'b1;
    tick();
    check = 1'b0;
  endtask

  task automatic unlock_then_relock(input string nm);
    shift_bits(PW, 32);
    do_check();
    chk_all({nm, "_unl"}, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_all({nm, "_rel"}, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    int lo_cycles;
    logic [32:0] long_word;

    tbl[0] = '{"unl_check_ign", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{"unl_shift_ign", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{"relock_pulse",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{"relock_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{"relock_locked", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset scrub
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d.en", i),  32'(unlock_en),  32'd1);
      chk($sformatf("rst%0d.val", i), 32'(unlock_val), 32'd0);
    end
    reset = 1'b0;
    chk("scrub_hold.en",  32'(unlock_en),  32'd1);
    chk("scrub_hold.val", 32'(unlock_val), 32'd0);
    tick();
    chk_all("post_scrub", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Correct unlock and pulse width
    shift_bits(PW, 32);
    chk_all("pre_check", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    do_check();
    chk_all("unlock", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("unlock_pulse_end", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    // Table: ignored inputs in UNLOCKED, relock, relock in LOCKED
    for (int i = 0; i < 5; i++) begin
      shift_en = tbl[i].sh;
      tdi      = tbl[i].bit_in;
      check    = tbl[i].chk_in;
      relock   = tbl[i].rel;
      tick();
      chk_all(tbl[i].name, tbl[i].en, tbl[i].val, tbl[i].unl, tbl[i].lo, tbl[i].fc);
    end
    shift_en = 1'b0; tdi = 1'b0; check = 1'b0; relock = 1'b0;

    // Short shift fails, overlong shift keeps the last 32 bits
    shift_bits(PW >> 1, 31);
    do_check();
    chk_all("short", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    long_word = {1'b1, PW};
    shift_bits(long_word[32:1], 32);
    shift_bits({31'd0, long_word[0]}, 1);
    do_check();
    chk_all("overlong", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_all("relock2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // Collision: check with the 32nd shift fails and clears sr/count
    shift_bits(PW >> 1, 31);
    shift_en = 1'b1;
    tdi      = PW[0];
    check    = 1'b1;
    tick();
    shift_en = 1'b0; check = 1'b0; tdi = 1'b0;
    chk_all("collision", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    shift_bits(PW, 1);
    do_check();
    chk_all("collision_clr", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    unlock_then_relock("recover");

    // Lockout after three wrong passwords
    for (int k = 1; k <= 3; k++) begin
      shift_bits(32'h0, 32);
      do_check();
      chk_all($sformatf("wrong%0d", k), 1'b0, 1'b0, 1'b0, (k == 3), 2'(k));
    end
    lo_cycles = 1;
    for (int k = 0; k < 100 && in_lockout; k++) begin
      shift_en = 1'b1;
      tdi      = PW[31 - (k % 32)];
      check    = (k == 6);
      tick();
      if (k == 6)
        chk_all("lockout_check_ign", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      if (in_lockout) lo_cycles++;
    end
    shift_en = 1'b0; tdi = 1'b0; check = 1'b0;
    chk("lockout_len", 32'(lo_cycles), 32'(LOCK_CYC));
    chk_all("lockout_end", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    unlock_then_relock("post_lockout");

    // Reset mid-lockout
    for (int k = 1; k <= 3; k++) do_check();
    chk_all("lock2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    for (int k = 0; k < 5; k++) tick();
    chk("lock2_mid.lo", 32'(in_lockout), 32'd1);
    reset = 1'b1;
    tick();
    chk_all("rst_lockout", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick();
    chk("rst_scrub.en", 32'(unlock_en), 32'd0);
    unlock_then_relock("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
